pll_reconfig_ctrl: RTL and testbench
====================================

// Module: pll_reconfig_ctrl
// PURPOSE
// - Sequencer for a Gowin rPLL with dynamic dividers (DYN_*_SEL="true"): drives RESET, IDSEL, FBDSEL, ODSEL.
// - Qualifies LOCK, generates the downstream synchronous reset and accepts runtime frequency-change requests.
// - Sits between the board clock input and the rPLL primitive; replaces fixed-divider PLL instantiation.
// PARAMETERS
// - RST_CYCLES    16      cycles pll_reset_o is held high per (re)start
// - LOCK_STABLE   1024    consecutive synced-lock cycles before lock is declared
// - LOCK_TIMEOUT  65536   cycles waiting for lock before one attempt fails
// - MAX_RETRY     3       failed attempts before entering FAIL
// - INIT_IDSEL    6'h3F   IDSEL code applied out of reset (raw dynamic code)
// - INIT_FBDSEL   6'h36   FBDSEL code applied out of reset
// - INIT_ODSEL    6'h3C   ODSEL code applied out of reset
// PORTS
// - clk           in   1   free-running reference clock (PLL input domain)
// - reset_n       in   1   asynchronous, active-low reset
// - req_valid     in   1   reconfiguration request
// - req_ready     out  1   request accepted when req_valid & req_ready
// - req_idsel     in   6   new IDSEL code (raw, passed through unmodified)
// - req_fbdsel    in   6   new FBDSEL code
// - req_odsel     in   6   new ODSEL code
// - pll_lock_i    in   1   rPLL LOCK (asynchronous to clk)
// - pll_reset_o   out  1   to rPLL RESET
// - idsel_o/fbdsel_o/odsel_o  out  6 each  to rPLL dynamic divider inputs
// - locked_o      out  1   qualified lock
// - sys_rst_n_o   out  1   downstream reset, low whenever locked_o is low
// - error_o       out  1   sticky: MAX_RETRY attempts failed; cleared on accepted request
// - loss_cnt_o    out  8   lock-loss count (only with PLL_LOSS_CNT_EN)
// BEHAVIOUR
// - Async reset: state=RESET_PLL, pll_reset_o=1, codes=INIT_*, req_ready=0, locked_o=0, sys_rst_n_o=0, error_o=0, retry=0, counters=0.
// - pll_lock_i passes through a 2-flop synchroniser (lk); all decisions use lk (2-cycle latency).
// - RESET_PLL: pll_reset_o=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK, pll_reset_o=0.
// - WAIT_LOCK: lk=1 -> STABLE (count cleared); cycle count reaching LOCK_TIMEOUT -> retry+1; retry<MAX_RETRY -> RESET_PLL, else FAIL.
// - STABLE: lk=0 restarts the stable count, stays in STABLE, timeout still running; LOCK_STABLE consecutive lk=1 cycles -> RUN, retry cleared.
// - RUN: locked_o=1; sys_rst_n_o=1 one cycle after locked_o; req_ready=1.
// - RUN, lk=0: locked_o and sys_rst_n_o drop next cycle; -> WAIT_LOCK without PLL reset.
// - FAIL: pll_reset_o=1, error_o=1, req_ready=1; stays until a request is accepted.
// - Accepted request (RUN or FAIL): codes latched to *_o same edge; locked_o=0, sys_rst_n_o=0, error_o=0, retry=0; -> RESET_PLL.
// - Request and lk=0 on the same RUN cycle: request wins.
// - req_ready=0 in RESET_PLL/WAIT_LOCK/STABLE; req_* are ignored there; the requester holds req_valid.
// - Counter widths are $clog2 of the largest parameter + 1; counters saturate and never wrap.
// CONFIGURATION
// - PLL_LOSS_CNT_EN defined: loss_cnt_o counts RUN->WAIT_LOCK lock losses.
//   - Saturates at 255; cleared by reset_n only; accepted requests do not clear it.
// - PLL_LOSS_CNT_EN undefined: loss_cnt_o tied to 8'h00 and no counter is built.
// STRUCTURE
// - pll_ctrl_pkg: state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL), PLL_CODE_W=6, LOSS_CNT_W=8.
// - Sub-module sync_2ff: lock synchroniser, reusable for other async inputs.
// - Top level holds the FSM, the cycle/retry counters and the code registers.
// TESTING (bench params: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2)
// - Release reset, lock=1 at cycle 10 -> pll_reset_o low after 4 cycles; locked_o=1 at 10+2+8; sys_rst_n_o one cycle later; codes=INIT_*.
// - Lock never asserts -> two 4-cycle reset pulses, 32-cycle waits; then FAIL, error_o=1, pll_reset_o=1.
// - In FAIL, request 3F/2D/3E -> *_o take new codes; error_o=0; new lock sequence; locked_o returns.
// - In RUN, lock 1-cycle glitch -> locked_o/sys_rst_n_o low 3 cycles later; no pll_reset pulse; relock after 8 stable cycles; loss_cnt_o=1 (with macro).
// - In STABLE, lock drops at stable count 5 -> count restarts; locked_o not asserted until 8 clean cycles.
// - req_valid during WAIT_LOCK -> req_ready=0, codes unchanged; accepted on the first RUN cycle.
// - Request on the same cycle as a lock drop in RUN -> reconfiguration taken; loss_cnt_o unchanged.
// - reset_n asserted mid-STABLE -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding, code widths and counter sizing for the rPLL reconfiguration controller.
// Combinational only: no latency and no flow control of its own.
package pll_ctrl_pkg;

  localparam int PLL_CODE_W = 6;
  localparam int LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_state_e;

  typedef struct packed {
    logic [PLL_CODE_W-1:0] idsel;
    logic [PLL_CODE_W-1:0] fbdsel;
    logic [PLL_CODE_W-1:0] odsel;
  } pll_codes_t;

  // Wide enough to hold the largest of the three cycle limits without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_sync_2ff.sv
// Two-flop synchroniser for one asynchronous level input; q_o follows d_i two clk edges later.
// No flow control: the input is sampled every cycle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rPLL sequencer: RESET pulse, dynamic divider codes, LOCK qualification (2-cycle sync) and downstream reset;
// requests stall (req_ready=0) outside RUN/FAIL. PLL_LOSS_CNT_EN adds the saturating lock-loss counter.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int                    RST_CYCLES   = 16,
  parameter int                    LOCK_STABLE  = 1024,
  parameter int                    LOCK_TIMEOUT = 65536,
  parameter int                    MAX_RETRY    = 3,
  parameter logic [PLL_CODE_W-1:0] INIT_IDSEL   = 6'h3F,
  parameter logic [PLL_CODE_W-1:0] INIT_FBDSEL  = 6'h36,
  parameter logic [PLL_CODE_W-1:0] INIT_ODSEL   = 6'h3C
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PLL_CODE_W-1:0] req_idsel,
  input  logic [PLL_CODE_W-1:0] req_fbdsel,
  input  logic [PLL_CODE_W-1:0] req_odsel,
  input  logic                  pll_lock_i,
  output logic                  pll_reset_o,
  output logic [PLL_CODE_W-1:0] idsel_o,
  output logic [PLL_CODE_W-1:0] fbdsel_o,
  output logic [PLL_CODE_W-1:0] odsel_o,
  output logic                  locked_o,
  output logic                  sys_rst_n_o,
  output logic                  error_o,
  output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT);
  localparam int RTY_W = $clog2(MAX_RETRY) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

  localparam pll_codes_t INIT_CODES = '{idsel: INIT_IDSEL, fbdsel: INIT_FBDSEL, odsel: INIT_ODSEL};

  pll_state_e       state_q;
  pll_codes_t       codes_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] tcnt_q;
  logic [RTY_W-1:0] retry_q;
  logic             prst_q;
  logic             ready_q;
  logic             locked_q;
  logic             sys_rst_n_q;
  logic             error_q;

  logic lk;
  logic req_fire;
  logic timeout;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (pll_lock_i),
    .q_o   (lk)
  );

  assign req_fire = req_valid & ready_q;
  assign timeout  = (tcnt_q == TO_LAST);

  // cnt_q times the reset pulse in RESET_PLL and the clean-lock run in STABLE;
  // tcnt_q spans the whole attempt (WAIT_LOCK + STABLE) so a flapping lock still times out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_PLL;
      codes_q     <= INIT_CODES;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      retry_q     <= '0;
      prst_q      <= 1'b1;
      ready_q     <= 1'b0;
      locked_q    <= 1'b0;
      sys_rst_n_q <= 1'b0;
      error_q     <= 1'b0;
    end else if (req_fire) begin
      codes_q     <= '{idsel: req_idsel, fbdsel: req_fbdsel, odsel: req_odsel};
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      prst_q      <= 1'b1;
      ready_q     <= 1'b0;
      locked_q    <= 1'b0;
      sys_rst_n_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_q <= WAIT_LOCK;
            prst_q  <= 1'b0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        WAIT_LOCK, STABLE: begin
          if (timeout) begin
            prst_q  <= 1'b1;
            cnt_q   <= '0;
            retry_q <= retry_q + RTY_W'(1);
            if (retry_q == RTY_LAST) begin
              state_q <= FAIL;
              error_q <= 1'b1;
              ready_q <= 1'b1;
            end else begin
              state_q <= RESET_PLL;
            end
          end else begin
            tcnt_q <= tcnt_q + CNT_W'(1);
            if (state_q == WAIT_LOCK) begin
              if (lk) begin
                state_q <= STABLE;
                cnt_q   <= '0;
              end
            end else if (!lk) begin
              cnt_q <= '0;
            end else if (cnt_q == STB_LAST) begin
              state_q  <= RUN;
              locked_q <= 1'b1;
              ready_q  <= 1'b1;
              retry_q  <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        RUN: begin
          if (!lk) begin
            state_q     <= WAIT_LOCK;
            locked_q    <= 1'b0;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            tcnt_q      <= '0;
          end else begin
            sys_rst_n_q <= 1'b1;
          end
        end

        FAIL: begin
        end

        default: begin
          state_q     <= RESET_PLL;
          cnt_q       <= '0;
          prst_q      <= 1'b1;
          ready_q     <= 1'b0;
          locked_q    <= 1'b0;
          sys_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;
  logic [LOSS_CNT_W-1:0] loss_d;

  // A request taken on the same cycle as a lock drop is a reconfiguration, not a loss.
  always_comb begin
    loss_d = loss_q;
    if ((state_q == RUN) && !req_fire && !lk && (loss_q != '1)) begin
      loss_d = loss_q + LOSS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_cnt_o = loss_q;
`else
  assign loss_cnt_o = '0;
`endif

  assign req_ready   = ready_q;
  assign pll_reset_o = prst_q;
  assign idsel_o     = codes_q.idsel;
  assign fbdsel_o    = codes_q.fbdsel;
  assign odsel_o     = codes_q.odsel;
  assign locked_o    = locked_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: directed scenario tasks plus a randomized run against a timestamp-based model.
`timescale 1ns/1ps
module tb_pll_reconfig_ctrl;

  localparam int RSTC = 4;
  localparam int STB  = 8;
  localparam int TO   = 32;
  localparam int MR   = 2;
  localparam logic [5:0] I_ID = 6'h3F;
  localparam logic [5:0] I_FB = 6'h36;
  localparam logic [5:0] I_OD = 6'h3C;

  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [5:0] req_id = '0, req_fb = '0, req_od = '0;
  logic       pll_lock = 1'b0;
  logic       pll_reset_o, locked_o, sys_rst_n_o, error_o;
  logic [5:0] idsel_o, fbdsel_o, odsel_o;
  logic [7:0] loss_cnt_o;

  int total = 0;
  int bad = 0;

  // Reference model state: phase plus timestamps of when the phase / attempt / clean run began.
  int   m_cyc, m_ph, m_t_ent, m_t_att, m_t_clean, m_fails, e_loss;
  bit   m_s1, m_lk, m_fire;
  bit   e_prst, e_ready, e_locked, e_sys, e_err;
  logic [5:0] e_id, e_fb, e_od;

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(
    .RST_CYCLES(RSTC), .LOCK_STABLE(STB), .LOCK_TIMEOUT(TO), .MAX_RETRY(MR),
    .INIT_IDSEL(I_ID), .INIT_FBDSEL(I_FB), .INIT_ODSEL(I_OD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_idsel(req_id), .req_fbdsel(req_fb), .req_odsel(req_od), .pll_lock_i(pll_lock),
    .pll_reset_o(pll_reset_o), .idsel_o(idsel_o), .fbdsel_o(fbdsel_o), .odsel_o(odsel_o),
    .locked_o(locked_o), .sys_rst_n_o(sys_rst_n_o), .error_o(error_o), .loss_cnt_o(loss_cnt_o)
  );

  function automatic void model_reset();
    m_cyc = 0; m_ph = P_RST; m_t_ent = 0; m_t_att = 0; m_t_clean = 0; m_fails = 0;
    m_s1 = 1'b0; m_lk = 1'b0; m_fire = 1'b0;
    e_prst = 1'b1; e_ready = 1'b0; e_locked = 1'b0; e_sys = 1'b0; e_err = 1'b0;
    e_id = I_ID; e_fb = I_FB; e_od = I_OD; e_loss = 0;
  endfunction

  function automatic void model_edge();
    bit lk_old;
    lk_old = m_lk;
    m_cyc++;
    m_lk = m_s1;
    m_s1 = pll_lock;
    m_fire = req_valid && e_ready;
    if (m_fire) begin
      e_id = req_id; e_fb = req_fb; e_od = req_od;
      e_locked = 1'b0; e_sys = 1'b0; e_err = 1'b0; e_ready = 1'b0; e_prst = 1'b1;
      m_fails = 0; m_ph = P_RST; m_t_ent = m_cyc;
    end else begin
      case (m_ph)
        P_RST: begin
          if (m_cyc - m_t_ent == RSTC) begin
            m_ph = P_WAIT; e_prst = 1'b0; m_t_att = m_cyc;
          end
        end
        P_WAIT, P_STAB: begin
          if (m_cyc - m_t_att == TO) begin
            m_fails++;
            e_prst = 1'b1;
            if (m_fails >= MR) begin
              m_ph = P_FAIL; e_err = 1'b1; e_ready = 1'b1;
            end else begin
              m_ph = P_RST; m_t_ent = m_cyc;
            end
          end else if (m_ph == P_WAIT) begin
            if (lk_old) begin
              m_ph = P_STAB; m_t_clean = m_cyc;
            end
          end else if (!lk_old) begin
            m_t_clean = m_cyc;
          end else if (m_cyc - m_t_clean == STB) begin
            m_ph = P_RUN; e_locked = 1'b1; e_ready = 1'b1; m_fails = 0;
          end
        end
        P_RUN: begin
          if (!lk_old) begin
            m_ph = P_WAIT; e_locked = 1'b0; e_sys = 1'b0; e_ready = 1'b0; m_t_att = m_cyc;
            if (e_loss < 255) e_loss++;
          end else begin
            e_sys = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  endfunction

  function automatic logic [7:0] want_loss(input int n);
`ifdef PLL_LOSS_CNT_EN
    return 8'(n);
`else
    return (n > 0) ? 8'h00 : 8'h00;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; req_valid = 1'b0; pll_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_lock = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({pll_reset_o, req_ready, locked_o, sys_rst_n_o, error_o} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl got %b want 10000", {pll_reset_o, req_ready, locked_o, sys_rst_n_o, error_o});
    end
    total++;
    if ({idsel_o, fbdsel_o, odsel_o} !== {I_ID, I_FB, I_OD}) begin
      bad++; $display("FAIL reset_codes got %h want %h", {idsel_o, fbdsel_o, odsel_o}, {I_ID, I_FB, I_OD});
    end
    total++;
    if (loss_cnt_o !== 8'h00) begin
      bad++; $display("FAIL reset_loss got %h want 00", loss_cnt_o);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_lock_up();
    logic [3:0] got, want;
    for (int c = 1; c <= 24; c++) begin
      pll_lock = (c >= 10);
      step();
      got  = {pll_reset_o, locked_o, sys_rst_n_o, req_ready};
      want = {c < 4, c >= 20, c >= 21, c >= 20};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL lock_up c=%0d got %b want %b", c, got, want);
      end
    end
    total++;
    if ({idsel_o, fbdsel_o, odsel_o, error_o} !== {I_ID, I_FB, I_OD, 1'b0}) begin
      bad++; $display("FAIL lock_up_codes got %h want %h", {idsel_o, fbdsel_o, odsel_o, error_o}, {I_ID, I_FB, I_OD, 1'b0});
    end
  endtask

  task automatic test_no_lock_fail();
    logic [3:0] got, want;
    logic p, e;
    apply_reset();
    for (int c = 1; c <= 80; c++) begin
      pll_lock = 1'b0;
      step();
      p = !((c >= 4 && c < 36) || (c >= 40 && c < 72));
      e = (c >= 72);
      got  = {pll_reset_o, error_o, req_ready, locked_o};
      want = {p, e, e, 1'b0};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL no_lock c=%0d got %b want %b", c, got, want);
      end
    end
  endtask

  task automatic test_fail_request();
    logic [2:0] got, want;
    req_valid = 1'b1; req_id = 6'h3F; req_fb = 6'h2D; req_od = 6'h3E;
    step();
    req_valid = 1'b0; pll_lock = 1'b1;
    total++;
    if ({idsel_o, fbdsel_o, odsel_o} !== {6'h3F, 6'h2D, 6'h3E}) begin
      bad++; $display("FAIL fail_req_codes got %h want 3f2d3e", {idsel_o, fbdsel_o, odsel_o});
    end
    total++;
    if ({error_o, req_ready, pll_reset_o, locked_o} !== 4'b0010) begin
      bad++; $display("FAIL fail_req_ctrl got %b want 0010", {error_o, req_ready, pll_reset_o, locked_o});
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      got  = {pll_reset_o, locked_o, sys_rst_n_o};
      want = {k < 4, k >= 13, k >= 14};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL fail_relock k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_run_glitch();
    logic [2:0] got, want;
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) step();
      got  = {pll_reset_o, locked_o, sys_rst_n_o};
      want = {1'b0, (k < 2) || (k >= 11), (k < 2) || (k >= 12)};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL glitch k=%0d got %b want %b", k, got, want);
      end
    end
    total++;
    if (loss_cnt_o !== want_loss(1)) begin
      bad++; $display("FAIL glitch_loss got %0d want %0d", loss_cnt_o, want_loss(1));
    end
  endtask

  task automatic test_stable_drop();
    logic [17:0] nc;
    logic [1:0] got, want;
    nc = 18'($urandom_range(0, 262143));
    req_valid = 1'b1; {req_id, req_fb, req_od} = nc;
    step();
    req_valid = 1'b0;
    total++;
    if ({idsel_o, fbdsel_o, odsel_o} !== nc) begin
      bad++; $display("FAIL run_req_codes got %h want %h", {idsel_o, fbdsel_o, odsel_o}, nc);
    end
    for (int k = 1; k <= 22; k++) begin
      pll_lock = (k != 9);
      step();
      got  = {locked_o, pll_reset_o};
      want = {k >= 19, k < 4};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL stable_drop k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_req_with_drop();
    logic [17:0] nc;
    nc = 18'($urandom_range(0, 262143));
    pll_lock = 1'b0;
    step();
    step();
    total++;
    if ({locked_o, req_ready} !== 2'b11) begin
      bad++; $display("FAIL drop_pre got %b want 11", {locked_o, req_ready});
    end
    req_valid = 1'b1; {req_id, req_fb, req_od} = nc;
    step();
    req_valid = 1'b0;
    total++;
    if ({idsel_o, fbdsel_o, odsel_o} !== nc) begin
      bad++; $display("FAIL drop_req_codes got %h want %h", {idsel_o, fbdsel_o, odsel_o}, nc);
    end
    total++;
    if ({locked_o, sys_rst_n_o, pll_reset_o, req_ready} !== 4'b0010) begin
      bad++; $display("FAIL drop_req_ctrl got %b want 0010", {locked_o, sys_rst_n_o, pll_reset_o, req_ready});
    end
    step();
    total++;
    if ({pll_reset_o, loss_cnt_o} !== {1'b1, want_loss(1)}) begin
      bad++; $display("FAIL drop_req_loss got %h want %h", {pll_reset_o, loss_cnt_o}, {1'b1, want_loss(1)});
    end
  endtask

  task automatic test_req_in_wait();
    logic [17:0] nc, wc;
    logic [2:0] got, want;
    nc = 18'($urandom_range(0, 262143));
    apply_reset();
    {req_id, req_fb, req_od} = nc;
    for (int c = 1; c <= 21; c++) begin
      pll_lock  = (c >= 10);
      req_valid = (c >= 5);
      step();
      got  = {req_ready, locked_o, pll_reset_o};
      want = {c == 20, c == 20, (c < 4) || (c == 21)};
      wc   = (c <= 20) ? {I_ID, I_FB, I_OD} : nc;
      total++;
      if (got !== want) begin
        bad++; $display("FAIL req_wait c=%0d got %b want %b", c, got, want);
      end
      total++;
      if ({idsel_o, fbdsel_o, odsel_o} !== wc) begin
        bad++; $display("FAIL req_wait_codes c=%0d got %h want %h", c, {idsel_o, fbdsel_o, odsel_o}, wc);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_random();
    int  seg;
    logic [4:0] got, want;
    seg = 0;
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      if (seg == 0) begin
        seg = ($urandom_range(0, 4) == 0) ? 1 : $urandom_range(1, 60);
        pll_lock = ($urandom_range(0, 3) != 0);
      end
      seg--;
      if (!req_valid && $urandom_range(0, 29) == 0) begin
        req_valid = 1'b1;
        req_id = 6'($urandom_range(0, 63)); req_fb = 6'($urandom_range(0, 63)); req_od = 6'($urandom_range(0, 63));
      end
      step();
      if (m_fire) req_valid = 1'b0;
      got  = {pll_reset_o, req_ready, locked_o, sys_rst_n_o, error_o};
      want = {e_prst, e_ready, e_locked, e_sys, e_err};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL rand_ctrl n=%0d got %b want %b", n, got, want);
      end
      total++;
      if ({idsel_o, fbdsel_o, odsel_o, loss_cnt_o} !== {e_id, e_fb, e_od, want_loss(e_loss)}) begin
        bad++; $display("FAIL rand_data n=%0d got %h want %h", n, {idsel_o, fbdsel_o, odsel_o, loss_cnt_o},
                        {e_id, e_fb, e_od, want_loss(e_loss)});
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [17:0] nc;
    nc = 18'($urandom_range(0, 262143));
    apply_reset();
    {req_id, req_fb, req_od} = nc;
    for (int c = 1; c <= 23; c++) begin
      pll_lock  = 1'b1;
      req_valid = (c == 14);
      step();
    end
    req_valid = 1'b0;
    total++;
    if ({pll_reset_o, locked_o, req_ready, idsel_o, fbdsel_o, odsel_o} !== {3'b000, nc}) begin
      bad++; $display("FAIL pre_areset got %h want %h", {pll_reset_o, locked_o, req_ready, idsel_o, fbdsel_o, odsel_o}, {3'b000, nc});
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({pll_reset_o, req_ready, locked_o, sys_rst_n_o, error_o} !== 5'b10000) begin
      bad++; $display("FAIL areset_ctrl got %b want 10000", {pll_reset_o, req_ready, locked_o, sys_rst_n_o, error_o});
    end
    total++;
    if ({idsel_o, fbdsel_o, odsel_o, loss_cnt_o} !== {I_ID, I_FB, I_OD, 8'h00}) begin
      bad++; $display("FAIL areset_codes got %h want %h", {idsel_o, fbdsel_o, odsel_o, loss_cnt_o}, {I_ID, I_FB, I_OD, 8'h00});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_up();
    test_no_lock_fail();
    test_fail_request();
    test_run_glitch();
    test_stable_drop();
    test_req_with_drop();
    test_req_in_wait();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
